// File: rtl/conv_mem_pkg.sv
// Shared types and default sizes for the convolution processor's host-side memory bridge.
package conv_mem_pkg;

    localparam int DEF_DATA_Y_WIDTH    = 8;
    localparam int DEF_SIZE_Y_WIDTH    = 5;
    localparam int DEF_MEMY_ADDR_WIDTH = 5;
    localparam int DEF_DATA_Z_WIDTH    = 16;
    localparam int DEF_MEMZ_ADDR_WIDTH = 6;
    localparam int SIZE_H              = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/conv_yz_memory_bridge_if.sv
// Host stream and processor memory-port signals of the bridge; slave is the bridge's view.
interface conv_yz_memory_bridge_if #(
    parameter int DATA_Y_WIDTH    = conv_mem_pkg::DEF_DATA_Y_WIDTH,
    parameter int SIZE_Y_WIDTH    = conv_mem_pkg::DEF_SIZE_Y_WIDTH,
    parameter int MEMY_ADDR_WIDTH = conv_mem_pkg::DEF_MEMY_ADDR_WIDTH,
    parameter int DATA_Z_WIDTH    = conv_mem_pkg::DEF_DATA_Z_WIDTH,
    parameter int MEMZ_ADDR_WIDTH = conv_mem_pkg::DEF_MEMZ_ADDR_WIDTH
) ();

    logic [SIZE_Y_WIDTH-1:0]    cfg_sizeY_i;
    logic                       load_start_i;
    logic                       y_valid_i;
    logic [DATA_Y_WIDTH-1:0]    y_data_i;
    logic                       y_ready_o;
    logic                       z_valid_o;
    logic [DATA_Z_WIDTH-1:0]    z_data_o;
    logic                       z_last_o;
    logic                       z_ready_i;
    logic                       busy_o;
    logic [MEMY_ADDR_WIDTH-1:0] memY_addr_i;
    logic [DATA_Y_WIDTH-1:0]    dataY_o;
    logic [SIZE_Y_WIDTH-1:0]    sizeY_o;
    logic                       start_o;
    logic                       writeZ_i;
    logic [MEMZ_ADDR_WIDTH-1:0] memZ_addr_i;
    logic [DATA_Z_WIDTH-1:0]    dataZ_i;
    logic                       done_i;

    modport slave (
        input  cfg_sizeY_i, load_start_i, y_valid_i, y_data_i, z_ready_i,
        input  memY_addr_i, writeZ_i, memZ_addr_i, dataZ_i, done_i,
        output y_ready_o, z_valid_o, z_data_o, z_last_o, busy_o,
        output dataY_o, sizeY_o, start_o
    );

    modport master (
        output cfg_sizeY_i, load_start_i, y_valid_i, y_data_i, z_ready_i,
        output memY_addr_i, writeZ_i, memZ_addr_i, dataZ_i, done_i,
        input  y_ready_o, z_valid_o, z_data_o, z_last_o, busy_o,
        input  dataY_o, sizeY_o, start_o
    );

endinterface

// File: rtl/conv_mem_ram.sv
// Simple RAM with synchronous write and combinational read; contents are not reset.
module conv_mem_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_yz_memory_bridge.sv
// Host-side sequencer: loads Y memory, fires the processor start, collects Z writes and streams Z back.
module conv_yz_memory_bridge #(
    parameter int DATA_Y_WIDTH    = conv_mem_pkg::DEF_DATA_Y_WIDTH,
    parameter int SIZE_Y_WIDTH    = conv_mem_pkg::DEF_SIZE_Y_WIDTH,
    parameter int MEMY_ADDR_WIDTH = conv_mem_pkg::DEF_MEMY_ADDR_WIDTH,
    parameter int DATA_Z_WIDTH    = conv_mem_pkg::DEF_DATA_Z_WIDTH,
    parameter int MEMZ_ADDR_WIDTH = conv_mem_pkg::DEF_MEMZ_ADDR_WIDTH,
    parameter int SIZE_H          = conv_mem_pkg::SIZE_H
) (
    input logic                    clk,
    input logic                    rst,
    conv_yz_memory_bridge_if.slave bus
);

    import conv_mem_pkg::*;

    state_t                     state_q;
    state_t                     state_d;
    logic [MEMY_ADDR_WIDTH-1:0] ycnt_q;
    logic [MEMZ_ADDR_WIDTH-1:0] zcnt_q;
    logic [SIZE_Y_WIDTH-1:0]    size_y_q;
    logic [MEMZ_ADDR_WIDTH-1:0] size_z_q;
    logic                       first_run_q;

    logic accept_job;
    logic y_beat;
    logic y_last;
    logic z_write;
    logic z_handshake;
    logic z_last;

    assign accept_job  = (state_q == IDLE) && bus.load_start_i && (bus.cfg_sizeY_i != '0);
    assign y_beat      = (state_q == LOAD) && bus.y_valid_i;
    assign y_last      = (ycnt_q == MEMY_ADDR_WIDTH'(size_y_q - 1'b1));
    assign z_handshake = (state_q == DRAIN) && bus.z_ready_i;
    assign z_last      = (zcnt_q == size_z_q - 1'b1);

    // Writes beyond the current job's Z length are dropped so stale results elsewhere survive.
    assign z_write     = (state_q == RUN) && bus.writeZ_i && (bus.memZ_addr_i < size_z_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_job)            state_d = LOAD;
            LOAD:    if (y_beat && y_last)      state_d = RUN;
            RUN:     if (bus.done_i)            state_d = DRAIN;
            DRAIN:   if (z_handshake && z_last) state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.y_ready_o = (state_q == LOAD);
        bus.z_valid_o = (state_q == DRAIN);
        bus.z_last_o  = (state_q == DRAIN) && z_last;
        bus.start_o   = (state_q == RUN) && first_run_q;
        bus.busy_o    = (state_q != IDLE);
    end

    // first_run_q marks the single cycle that follows the last Y beat, which is the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ycnt_q      <= '0;
            zcnt_q      <= '0;
            size_y_q    <= '0;
            size_z_q    <= '0;
            first_run_q <= 1'b0;
        end else begin
            first_run_q <= y_beat && y_last;
            if (accept_job) begin
                size_y_q <= bus.cfg_sizeY_i;
                size_z_q <= MEMZ_ADDR_WIDTH'(bus.cfg_sizeY_i) + MEMZ_ADDR_WIDTH'(SIZE_H - 1);
                ycnt_q   <= '0;
            end else if (y_beat) begin
                ycnt_q <= ycnt_q + 1'b1;
            end
            if ((state_q == RUN) && bus.done_i) begin
                zcnt_q <= '0;
            end else if (z_handshake) begin
                zcnt_q <= zcnt_q + 1'b1;
            end
        end
    end

    assign bus.sizeY_o = size_y_q;

    conv_mem_ram #(
        .DATA_WIDTH (DATA_Y_WIDTH),
        .ADDR_WIDTH (MEMY_ADDR_WIDTH)
    ) u_mem_y (
        .clk   (clk),
        .we    (y_beat),
        .waddr (ycnt_q),
        .wdata (bus.y_data_i),
        .raddr (bus.memY_addr_i),
        .rdata (bus.dataY_o)
    );

    conv_mem_ram #(
        .DATA_WIDTH (DATA_Z_WIDTH),
        .ADDR_WIDTH (MEMZ_ADDR_WIDTH)
    ) u_mem_z (
        .clk   (clk),
        .we    (z_write),
        .waddr (bus.memZ_addr_i),
        .wdata (bus.dataZ_i),
        .raddr (zcnt_q),
        .rdata (bus.z_data_o)
    );

endmodule

// File: tb/tb_conv_yz_memory_bridge.sv
// Directed bench for the Y/Z memory bridge; Z beats are checked by a scoreboard-driven monitor.
module tb_conv_yz_memory_bridge;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic  clk;
    logic  rst;
    int    vectors;
    int    miscompares;
    int    start_count;
    int    model_size_z;
    int    snap;
    logic [15:0] model_z [64];
    beat_t exp_q [$];

    logic        held_valid;
    logic [15:0] held_data;
    logic        held_last;

    conv_yz_memory_bridge_if bus ();

    conv_yz_memory_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int size);
        bus.cfg_sizeY_i  = 5'(size);
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        if (size != 0) model_size_z = size + 9;
    endtask

    task automatic load_y(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.y_valid_i = 1'b1;
            bus.y_data_i  = 8'(base + i);
            tick();
        end
        bus.y_valid_i = 1'b0;
    endtask

    // Processor-side command; on done the full expected Z stream is queued from the bench model.
    task automatic proc_cmd(input bit wr, input int addr, input int data, input bit done);
        bus.writeZ_i    = wr;
        bus.memZ_addr_i = 6'(addr);
        bus.dataZ_i     = 16'(data);
        bus.done_i      = done;
        if (wr && addr < model_size_z) model_z[addr] = 16'(data);
        if (done) begin
            check_output("z_valid_before_done", 32'(bus.z_valid_o), 32'd0);
            for (int k = 0; k < model_size_z; k++) begin
                exp_q.push_back('{data: model_z[k], last: (k == model_size_z - 1)});
            end
        end
        tick();
        bus.writeZ_i = 1'b0;
        bus.done_i   = 1'b0;
        if (done) check_output("z_valid_after_done", 32'(bus.z_valid_o), 32'd1);
    endtask

    task automatic drain(input bit toggle, input string tag);
        bit finished = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.z_ready_i = toggle ? ~bus.z_ready_i : 1'b1;
            tick();
            if (exp_q.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        bus.z_ready_i = 1'b0;
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_drain_timeout: got %0d beats left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        check_output({tag, "_busy_after_drain"}, 32'(bus.busy_o), 32'd0);
    endtask

    // Monitor: pops an expected beat on every Z handshake and checks data is held while stalled.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst) begin
            if (bus.start_o) start_count++;
            if (held_valid && bus.z_valid_o) begin
                check_output("z_hold_data", 32'(bus.z_data_o), 32'(held_data));
                check_output("z_hold_last", 32'(bus.z_last_o), 32'(held_last));
            end
            if (bus.z_valid_o && bus.z_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL z_unexpected_beat: got 0x%0h, expected no beat", bus.z_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check_output("z_data", 32'(bus.z_data_o), 32'(e.data));
                    check_output("z_last", 32'(bus.z_last_o), 32'(e.last));
                end
            end
            held_valid = bus.z_valid_o && !bus.z_ready_i;
            held_data  = bus.z_data_o;
            held_last  = bus.z_last_o;
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : stimulus
        vectors          = 0;
        miscompares      = 0;
        start_count      = 0;
        model_size_z     = 0;
        held_valid       = 1'b0;
        held_data        = '0;
        held_last        = 1'b0;
        rst              = 1'b1;
        bus.cfg_sizeY_i  = '0;
        bus.load_start_i = 1'b0;
        bus.y_valid_i    = 1'b0;
        bus.y_data_i     = '0;
        bus.z_ready_i    = 1'b0;
        bus.memY_addr_i  = '0;
        bus.writeZ_i     = 1'b0;
        bus.memZ_addr_i  = '0;
        bus.dataZ_i      = '0;
        bus.done_i       = 1'b0;
        repeat (3) tick();

        check_output("rst_busy",    32'(bus.busy_o),    32'd0);
        check_output("rst_y_ready", 32'(bus.y_ready_o), 32'd0);
        check_output("rst_z_valid", 32'(bus.z_valid_o), 32'd0);
        check_output("rst_z_last",  32'(bus.z_last_o),  32'd0);
        check_output("rst_start",   32'(bus.start_o),   32'd0);
        check_output("rst_sizeY",   32'(bus.sizeY_o),   32'd0);
        rst = 1'b0;
        tick();

        // A zero-length job request must be ignored.
        start_job(0);
        check_output("zero_size_busy",    32'(bus.busy_o),    32'd0);
        check_output("zero_size_y_ready", 32'(bus.y_ready_o), 32'd0);

        // Job A: maximum length, fills every Z address 0..39.
        snap = start_count;
        start_job(31);
        check_output("A_busy",    32'(bus.busy_o),    32'd1);
        check_output("A_y_ready", 32'(bus.y_ready_o), 32'd1);
        check_output("A_sizeY",   32'(bus.sizeY_o),   32'd31);
        load_y(31, 100);
        check_output("A_y_ready_drop", 32'(bus.y_ready_o), 32'd0);
        check_output("A_start",        32'(bus.start_o),   32'd1);
        bus.memY_addr_i = 5'd30;
        #1;
        check_output("A_dataY_30", 32'(bus.dataY_o), 32'd130);
        for (int k = 0; k < 40; k++) proc_cmd(1'b1, k, 1000 + k, k == 39);
        drain(1'b0, "A");
        check_output("A_start_pulses", 32'(start_count - snap), 32'd1);

        // Job B: size 4, ignored load_start in RUN, dropped writes, write+done together, stalled drain.
        snap = start_count;
        start_job(4);
        load_y(4, 1);
        check_output("B_y_ready_drop", 32'(bus.y_ready_o), 32'd0);
        check_output("B_start",        32'(bus.start_o),   32'd1);
        bus.memY_addr_i = 5'd2;
        #1;
        check_output("B_dataY_2", 32'(bus.dataY_o), 32'd3);
        tick();
        check_output("B_start_low", 32'(bus.start_o), 32'd0);
        bus.cfg_sizeY_i  = 5'd7;
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
        check_output("B_run_sizeY",   32'(bus.sizeY_o),   32'd4);
        check_output("B_run_busy",    32'(bus.busy_o),    32'd1);
        check_output("B_run_y_ready", 32'(bus.y_ready_o), 32'd0);
        for (int k = 0; k < 12; k++) proc_cmd(1'b1, k, k * 10, 1'b0);
        proc_cmd(1'b1, 50, 16'hDEAD, 1'b0);
        proc_cmd(1'b1, 13, 16'hBEEF, 1'b0);
        proc_cmd(1'b1, 12, 120, 1'b1);
        drain(1'b1, "B");
        check_output("B_start_pulses", 32'(start_count - snap), 32'd1);

        // Y beats outside LOAD must not touch memory.
        bus.y_valid_i = 1'b1;
        bus.y_data_i  = 8'hEE;
        tick();
        bus.y_valid_i   = 1'b0;
        bus.memY_addr_i = 5'd4;
        #1;
        check_output("idle_y_ignored", 32'(bus.dataY_o), 32'd104);

        // Abort a load after two beats, then run job C with size 2.
        snap = start_count;
        start_job(4);
        load_y(2, 50);
        rst = 1'b1;
        tick();
        check_output("abort_busy",    32'(bus.busy_o),    32'd0);
        check_output("abort_y_ready", 32'(bus.y_ready_o), 32'd0);
        check_output("abort_sizeY",   32'(bus.sizeY_o),   32'd0);
        rst = 1'b0;
        tick();
        start_job(2);
        load_y(2, 200);
        check_output("C_start", 32'(bus.start_o), 32'd1);
        bus.memY_addr_i = 5'd1;
        #1;
        check_output("C_dataY_1", 32'(bus.dataY_o), 32'd201);
        for (int k = 0; k < 11; k++) proc_cmd(1'b1, k, 500 + k, k == 10);
        drain(1'b0, "C");
        check_output("C_start_pulses", 32'(start_count - snap), 32'd1);

        // Job D: done in the first RUN cycle; addr 13 must still hold job A's value.
        start_job(5);
        load_y(5, 60);
        check_output("D_start", 32'(bus.start_o), 32'd1);
        proc_cmd(1'b0, 0, 0, 1'b1);
        drain(1'b1, "D");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
